// File: rtl/ysyx_23060240_mem_arbiter_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : ysyx_23060240_mem_arbiter_if
// Brief    : Request/response bus used by IFU, LSU and the data-memory port.
//            master = the side issuing requests, slave = the side serving them.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
interface ysyx_23060240_mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic [ADDR_W-1:0]     req_addr;
   logic                  req_wen;
   logic [DATA_W-1:0]     req_wdata;
   logic [DATA_W/8-1:0]   req_wmask;
   logic                  resp_valid;
   logic [DATA_W-1:0]     resp_data;
   logic                  resp_err;

   modport master (
      output req_valid, req_addr, req_wen, req_wdata, req_wmask,
      input  req_ready, resp_valid, resp_data, resp_err
   );

   modport slave (
      input  req_valid, req_addr, req_wen, req_wdata, req_wmask,
      output req_ready, resp_valid, resp_data, resp_err
   );
endinterface
`default_nettype wire

// File: rtl/ysyx_23060240_mem_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : ysyx_23060240_mem_arbiter
// Brief    : 2:1 round-robin arbiter sharing the data-memory port between IFU
//            and LSU. One outstanding transaction; request is latched, issued,
//            and the response routed back to its owner.
//            Optional macro MEM_ARB_TIMEOUT_EN adds a response watchdog.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module ysyx_23060240_mem_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic clk,
   input  logic rst,
   ysyx_23060240_mem_arbiter_if.slave  ifu,
   ysyx_23060240_mem_arbiter_if.slave  lsu,
   ysyx_23060240_mem_arbiter_if.master mem
);

   localparam int         c_MASK_W  = DATA_W / 8;
   localparam logic [1:0] c_IDLE    = 2'd0;
   localparam logic [1:0] c_SEND    = 2'd1;
   localparam logic [1:0] c_WAIT    = 2'd2;
   localparam logic       c_OWN_IFU = 1'b0;
   localparam logic       c_OWN_LSU = 1'b1;

   logic [1:0]          r_state;
   logic                r_owner;
   logic                r_last_grant;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_wen;
   logic [DATA_W-1:0]   r_wdata;
   logic [c_MASK_W-1:0] r_wmask;

   logic                w_grant_lsu;
   logic                w_grant_ifu;
   logic                w_idle;
   logic                w_accept;
   logic                w_send_done;
   logic                w_resp_fire;
   logic                w_timeout;
   logic                w_done;
   logic [DATA_W-1:0]   w_resp_data;
   logic                w_resp_err;
   logic                w_unused_ok;

   // IFU requests never carry write data; fold those bits away explicitly.
   assign w_unused_ok = ^{ifu.req_wen, ifu.req_wdata, ifu.req_wmask};

   // Winner selection: a lone requester wins; on a tie the one not served last wins.
   always_comb begin
      w_grant_lsu = lsu.req_valid & (~ifu.req_valid | (r_last_grant == c_OWN_IFU));
      w_grant_ifu = ifu.req_valid & ~w_grant_lsu;
   end

   // Handshake qualifiers; rst masks everything so no ready/valid leaks while resetting.
   always_comb begin
      w_idle      = (r_state == c_IDLE) & ~rst;
      w_accept    = w_idle & (ifu.req_valid | lsu.req_valid);
      w_send_done = (r_state == c_SEND) & ~rst & mem.req_ready;
      w_resp_fire = (r_state == c_WAIT) & ~rst & mem.resp_valid;
      w_done      = w_resp_fire | w_timeout;
      w_resp_data = w_resp_fire ? mem.resp_data : '0;
      w_resp_err  = w_resp_fire ? mem.resp_err  : w_timeout;
   end

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int c_CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [c_CNT_W-1:0] r_wait_cnt;

   assign w_timeout = (r_state == c_WAIT) & ~rst & ~mem.resp_valid
                      & (r_wait_cnt == c_CNT_W'(TIMEOUT_CYC));

   // Watchdog: counts WAIT cycles without a response, restarted on each issue.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wait_cnt <= '0;
      end else if (w_send_done) begin
         r_wait_cnt <= '0;
      end else if ((r_state == c_WAIT) && !mem.resp_valid && !w_timeout) begin
         r_wait_cnt <= r_wait_cnt + 1'b1;
      end
   end
`else
   localparam int c_unused_timeout = TIMEOUT_CYC;
   assign w_timeout = 1'b0;
`endif

   // Requester handshakes and owner-steered responses (data/err zero when not valid).
   assign ifu.req_ready  = w_idle & w_grant_ifu;
   assign lsu.req_ready  = w_idle & w_grant_lsu;
   assign ifu.resp_valid = w_done & (r_owner == c_OWN_IFU);
   assign lsu.resp_valid = w_done & (r_owner == c_OWN_LSU);
   assign ifu.resp_data  = (w_done && r_owner == c_OWN_IFU) ? w_resp_data : '0;
   assign ifu.resp_err   = w_done & (r_owner == c_OWN_IFU) & w_resp_err;
   assign lsu.resp_data  = (w_done && r_owner == c_OWN_LSU) ? w_resp_data : '0;
   assign lsu.resp_err   = w_done & (r_owner == c_OWN_LSU) & w_resp_err;

   // Memory side is driven purely from the latched copy so it stays stable under backpressure.
   assign mem.req_valid = (r_state == c_SEND) & ~rst;
   assign mem.req_addr  = r_addr;
   assign mem.req_wen   = r_wen;
   assign mem.req_wdata = r_wdata;
   assign mem.req_wmask = r_wmask;

   // Transaction sequencing: IDLE -> SEND -> WAIT -> IDLE; stray responses outside WAIT are ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_IDLE;
      end else begin
         case (r_state)
            c_IDLE:  if (w_accept)    r_state <= c_SEND;
            c_SEND:  if (w_send_done) r_state <= c_WAIT;
            c_WAIT:  if (w_done)      r_state <= c_IDLE;
            default: r_state <= c_IDLE;
         endcase
      end
   end

   // Latch the winning request; an instruction fetch is a full-word read.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_owner      <= c_OWN_IFU;
         r_last_grant <= c_OWN_IFU;
         r_addr       <= '0;
         r_wen        <= 1'b0;
         r_wdata      <= '0;
         r_wmask      <= '0;
      end else if (w_accept) begin
         if (w_grant_lsu) begin
            r_owner      <= c_OWN_LSU;
            r_last_grant <= c_OWN_LSU;
            r_addr       <= lsu.req_addr;
            r_wen        <= lsu.req_wen;
            r_wdata      <= lsu.req_wdata;
            r_wmask      <= lsu.req_wmask;
         end else begin
            r_owner      <= c_OWN_IFU;
            r_last_grant <= c_OWN_IFU;
            r_addr       <= ifu.req_addr;
            r_wen        <= 1'b0;
            r_wdata      <= '0;
            r_wmask      <= '1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060240_mem_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_ysyx_23060240_mem_arbiter
// Brief    : Directed + random bench for the IFU/LSU memory arbiter, checked
//            cycle by cycle against a transaction-level reference model.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module tb_ysyx_23060240_mem_arbiter;

   localparam int TO = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ysyx_23060240_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifu_bus ();
   ysyx_23060240_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) lsu_bus ();
   ysyx_23060240_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

   ysyx_23060240_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
      .clk (clk),
      .rst (rst),
      .ifu (ifu_bus),
      .lsu (lsu_bus),
      .mem (mem_bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: one pending transaction, described by what has happened to it.
   bit          m_busy, m_issued, m_owner_lsu, m_last_lsu, m_fresh;
   int          m_wait;
   logic [31:0] m_addr, m_wdata;
   logic        m_wen;
   logic [3:0]  m_wmask;
   int          acc_win;          // 0 none, 1 IFU, 2 LSU accepted at last edge (model view)

   // Sampled DUT values of the last cycle
   logic        s_ifu_ready, s_lsu_ready, s_ifu_rv, s_lsu_rv;
   logic [31:0] s_ifu_rdata;
   int          gq[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: compare at the negedge, then advance the model on the posedge.
   task automatic cycle();
      int          win;
      logic        e_ir, e_lr, e_mv, fire, tmo, e_iv, e_lv, e_e;
      logic [31:0] e_d;
      #4;
      win = 0;
      if (!rst) begin
         if (ifu_bus.req_valid && lsu_bus.req_valid) win = m_last_lsu ? 1 : 2;
         else if (ifu_bus.req_valid)                 win = 1;
         else if (lsu_bus.req_valid)                 win = 2;
      end
      e_ir = !rst && !m_busy && (win == 1);
      e_lr = !rst && !m_busy && (win == 2);
      e_mv = !rst && m_busy && !m_issued;
      fire = !rst && m_busy && m_issued && mem_bus.resp_valid;
      tmo  = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      tmo  = !rst && m_busy && m_issued && !mem_bus.resp_valid && (m_wait == TO);
`endif
      e_iv = (fire || tmo) && !m_owner_lsu;
      e_lv = (fire || tmo) &&  m_owner_lsu;
      e_d  = fire ? mem_bus.resp_data : 32'h0;
      e_e  = fire ? mem_bus.resp_err  : tmo;

      check("ifu_req_ready",  ifu_bus.req_ready,  e_ir);
      check("lsu_req_ready",  lsu_bus.req_ready,  e_lr);
      check("mem_req_valid",  mem_bus.req_valid,  e_mv);
      check("ifu_resp_valid", ifu_bus.resp_valid, e_iv);
      check("lsu_resp_valid", lsu_bus.resp_valid, e_lv);
      check("ifu_resp_data",  ifu_bus.resp_data,  e_iv ? e_d : 32'h0);
      check("ifu_resp_err",   ifu_bus.resp_err,   e_iv ? e_e : 1'b0);
      check("lsu_resp_data",  lsu_bus.resp_data,  e_lv ? e_d : 32'h0);
      check("lsu_resp_err",   lsu_bus.resp_err,   e_lv ? e_e : 1'b0);
      if (m_fresh || e_mv) begin
         check("mem_req_addr",  mem_bus.req_addr,  m_addr);
         check("mem_req_wen",   mem_bus.req_wen,   m_wen);
         check("mem_req_wdata", mem_bus.req_wdata, m_wdata);
         check("mem_req_wmask", mem_bus.req_wmask, m_wmask);
      end
      s_ifu_ready = ifu_bus.req_ready;
      s_lsu_ready = lsu_bus.req_ready;
      s_ifu_rv    = ifu_bus.resp_valid;
      s_lsu_rv    = lsu_bus.resp_valid;
      s_ifu_rdata = ifu_bus.resp_data;

      @(posedge clk);
      acc_win = 0;
      if (rst) begin
         m_busy = 0; m_issued = 0; m_owner_lsu = 0; m_last_lsu = 0; m_wait = 0;
         m_addr = 0; m_wen = 0; m_wdata = 0; m_wmask = 0; m_fresh = 1;
      end else if (!m_busy && win != 0) begin
         acc_win = win;
         m_busy = 1; m_issued = 0; m_fresh = 0;
         m_owner_lsu = (win == 2); m_last_lsu = (win == 2);
         if (win == 2) begin
            m_addr = lsu_bus.req_addr; m_wen = lsu_bus.req_wen;
            m_wdata = lsu_bus.req_wdata; m_wmask = lsu_bus.req_wmask;
         end else begin
            m_addr = ifu_bus.req_addr; m_wen = 1'b0; m_wdata = 32'h0; m_wmask = 4'hF;
         end
      end else if (e_mv && mem_bus.req_ready) begin
         m_issued = 1; m_wait = 0;
      end else if (fire || tmo) begin
         m_busy = 0;
      end else if (m_busy && m_issued) begin
         m_wait++;
      end
      #1;
   endtask

   // Accept -> optional stall -> handshake -> optional wait -> response.
   task automatic run_txn(input int rdy_dly, input int rsp_dly, input logic [31:0] rdata,
                          input logic rerr, input bit keep, input bit spur);
      mem_bus.req_ready = 0; mem_bus.resp_valid = 0;
      cycle();
      gq.push_back(s_lsu_ready ? 2 : (s_ifu_ready ? 1 : 0));
      if (!keep) begin
         if (acc_win == 1) ifu_bus.req_valid = 0;
         if (acc_win == 2) lsu_bus.req_valid = 0;
      end
      for (int i = 0; i < rdy_dly; i++) begin
         mem_bus.resp_valid = spur; mem_bus.resp_data = $urandom;
         cycle();
      end
      mem_bus.resp_valid = 0; mem_bus.req_ready = 1;
      cycle();
      mem_bus.req_ready = 0;
      repeat (rsp_dly) cycle();
      mem_bus.resp_valid = 1; mem_bus.resp_data = rdata; mem_bus.resp_err = rerr;
      cycle();
      mem_bus.resp_valid = 0; mem_bus.resp_err = 0;
   endtask

   initial begin
      int exp_order[4];
      exp_order = '{2, 1, 2, 1};
      m_busy = 0; m_issued = 0; m_owner_lsu = 0; m_last_lsu = 0; m_fresh = 0; m_wait = 0;
      m_addr = 0; m_wen = 0; m_wdata = 0; m_wmask = 0; acc_win = 0;
      ifu_bus.req_wen = 0; ifu_bus.req_wdata = 0; ifu_bus.req_wmask = 0;
      mem_bus.req_ready = 0; mem_bus.resp_valid = 0; mem_bus.resp_data = 0; mem_bus.resp_err = 0;

      // Reset with both requesting, then tie round-robin with a held-off store
      rst = 1;
      ifu_bus.req_valid = 1; ifu_bus.req_addr = 32'h8000_0000;
      lsu_bus.req_valid = 1; lsu_bus.req_addr = 32'h8000_1000; lsu_bus.req_wen = 1;
      lsu_bus.req_wdata = 32'hDEAD_BEEF; lsu_bus.req_wmask = 4'h3;
      cycle();
      cycle();
      rst = 0;
      run_txn(5, 1, 32'h1111_0000, 0, 1, 0);
      run_txn(0, 0, 32'h2222_0000, 0, 1, 0);
      run_txn(0, 2, 32'h3333_0000, 1, 1, 0);
      run_txn(0, 0, 32'h4444_0000, 0, 1, 0);
      for (int i = 0; i < 4; i++) check($sformatf("tie_grant_%0d", i), gq[i], exp_order[i]);
      ifu_bus.req_valid = 0; lsu_bus.req_valid = 0;
      cycle();

      // Minimum-latency IFU fetch
      ifu_bus.req_valid = 1; ifu_bus.req_addr = 32'h8000_0000;
      run_txn(0, 0, 32'h0000_0413, 0, 0, 0);
      check("fetch_pulse", s_ifu_rv, 1'b1);
      check("fetch_data", s_ifu_rdata, 32'h0000_0413);
      check("fetch_no_lsu", s_lsu_rv, 1'b0);

      // Spurious responses in IDLE and SEND
      mem_bus.resp_valid = 1; mem_bus.resp_data = 32'hBAD0_0001;
      cycle();
      cycle();
      lsu_bus.req_valid = 1; lsu_bus.req_addr = 32'h8000_2004; lsu_bus.req_wen = 0;
      lsu_bus.req_wdata = 32'h0; lsu_bus.req_wmask = 4'hF;
      run_txn(3, 2, 32'hCAFE_F00D, 1, 0, 1);

      // Reset while waiting for the response
      ifu_bus.req_valid = 1; ifu_bus.req_addr = 32'h8000_0010;
      cycle();
      ifu_bus.req_valid = 0; mem_bus.req_ready = 1;
      cycle();
      mem_bus.req_ready = 0;
      cycle();
      rst = 1; mem_bus.resp_valid = 1; mem_bus.resp_data = 32'h5555_AAAA;
      cycle();
      rst = 0; mem_bus.resp_valid = 0;
      cycle();
      lsu_bus.req_valid = 1; lsu_bus.req_addr = 32'h8000_3000; lsu_bus.req_wen = 1;
      lsu_bus.req_wdata = 32'h1234_5678; lsu_bus.req_wmask = 4'hC;
      run_txn(1, 0, 32'h0, 0, 0, 0);

      // Long silence from memory (watchdog fires only when enabled)
      ifu_bus.req_valid = 1; ifu_bus.req_addr = 32'h8000_0020;
      cycle();
      ifu_bus.req_valid = 0; mem_bus.req_ready = 1;
      cycle();
      mem_bus.req_ready = 0;
      repeat (12) cycle();
      mem_bus.resp_valid = 1; mem_bus.resp_data = 32'h7777_0000;
      cycle();
      mem_bus.resp_valid = 0;
      cycle();

      // Random traffic: requesters hold valid until granted
      for (int n = 0; n < 400; n++) begin
         rst = ($urandom_range(0, 96) == 0);
         mem_bus.req_ready  = $urandom_range(0, 1);
         mem_bus.resp_valid = ($urandom_range(0, 2) == 0);
         mem_bus.resp_data  = $urandom;
         mem_bus.resp_err   = ($urandom_range(0, 7) == 0);
         if (!ifu_bus.req_valid || acc_win == 1) begin
            ifu_bus.req_valid = $urandom_range(0, 1);
            ifu_bus.req_addr  = $urandom;
         end
         if (!lsu_bus.req_valid || acc_win == 2) begin
            lsu_bus.req_valid = $urandom_range(0, 1);
            lsu_bus.req_addr  = $urandom;
            lsu_bus.req_wen   = $urandom_range(0, 1);
            lsu_bus.req_wdata = $urandom;
            lsu_bus.req_wmask = 4'($urandom);
         end
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
